multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control FSM that sequences the shared datapath: PC, IR, register file, ALU, immediate extender and one shared instruction/data memory port. Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB. Per state, the block drives the datapath muxes, the write enables, the ALU operation and the extender mode. The extender mode is zero-extend for logical immediates and sign-extend everywhere else. Memory accesses use a request/ready handshake, so wait states stretch FETCH and MEM.

---
 rtl/multi_cycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the shared datapath selects, write enables, ALU operation and extender mode.
module multi_cycle_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic [1:0] pc_src_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       ext_sign_o,
   output logic       illegal_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_e;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_RT  = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_AND = 3'd5;

   state_e state_q, state_d;
   logic   op_legal;

   always_comb begin
      unique case (instr_op_i)
         OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
         default:                       op_legal = 1'b0;
      endcase
   end

   // Async reset puts the FSM in IDLE, whose outputs are all zero, so every
   // enable and the memory request drop the moment rst_i falls.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output and state_d gets a default first, so no path can infer a latch.
      state_d      = state_q;
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 2'd0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      alu_op_o     = ALU_ADD;
      ext_sign_o   = 1'b0;
      illegal_o    = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = 2'd1;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = S_DECODE;
            end
         end

         // Branch target (PC + imm<<2) is precomputed here while the opcode is decoded.
         S_DECODE: begin
            alu_src_b_o = 2'd3;
            ext_sign_o  = 1'b1;
            if (instr_op_i == OP_J) begin
               pc_write_o = 1'b1;
               pc_src_o   = 2'd2;
               state_d    = S_FETCH;
            end else if (!op_legal) begin
               illegal_o = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
            state_d     = S_WB;
            case (instr_op_i)
               OP_R: begin
                  alu_src_b_o = 2'd0;
                  alu_op_o    = ALU_RT;
               end
               OP_ADDI: ext_sign_o = 1'b1;
               OP_SLTI: begin
                  alu_op_o   = ALU_SLT;
                  ext_sign_o = 1'b1;
               end
               OP_ANDI: alu_op_o = ALU_AND;
               OP_ORI:  alu_op_o = ALU_OR;
               OP_LW, OP_SW: begin
                  ext_sign_o = 1'b1;
                  state_d    = S_MEM;
               end
               OP_BEQ, OP_BNE: begin
                  alu_src_b_o = 2'd0;
                  alu_op_o    = ALU_SUB;
                  pc_src_o    = 2'd1;
                  pc_write_o  = (instr_op_i == OP_BEQ) ? zero_i : !zero_i;
                  state_d     = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end

         S_MEM: begin
            mem_req_o   = 1'b1;
            mem_write_o = (instr_op_i == OP_SW);
            if (mem_ready_i) state_d = (instr_op_i == OP_SW) ? S_FETCH : S_WB;
         end

         S_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = (instr_op_i == OP_R);
            mem_to_reg_o = (instr_op_i == OP_LW);
            state_d      = S_FETCH;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized scoreboard bench for multi_cycle_ctrl: a per-instruction model pushes the
// expected output vector of every cycle; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       ext_sign;
      logic       illegal;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] instr_op_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       mem_req_o, mem_write_o, ir_write_o, pc_write_o;
   logic [1:0] pc_src_o;
   logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [2:0] alu_op_o;
   logic       ext_sign_o, illegal_o;
   logic [2:0] state_o;

   multi_cycle_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .instr_op_i   (instr_op_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_write_o  (mem_write_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .reg_write_o  (reg_write_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .ext_sign_o   (ext_sign_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   exp_t act;
   assign act = {state_o, mem_req_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
                 reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                 alu_op_o, ext_sign_o, illegal_o};

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cycle_no = 0;
   logic [5:0] cur_op = 6'h00;

   localparam logic [5:0] LEGAL_OPS [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                              6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};

   task automatic check(input string name, input exp_t got, input exp_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h (state %0d) want %h (state %0d)",
                  name, cycle_no, got, got.state, want, want.state);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e = '0;
      e.state = st;
      return e;
   endfunction

   function automatic logic rnd_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   // Advance one cycle, drive inputs just after the edge, and queue what the outputs must be.
   task automatic drive_cycle(input exp_t e, input logic ready, input logic zero,
                              input logic [5:0] op);
      @(posedge clk_i);
      #1;
      mem_ready_i = ready;
      zero_i      = zero;
      instr_op_i  = op;
      exp_q.push_back(e);
   endtask

   // Reference model: one instruction from FETCH entry to its last state, with fw/mw wait cycles.
   task automatic run_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
      exp_t e;
      bit   legal  = is_legal(op);
      bit   branch = (op == 6'h04) || (op == 6'h05);
      bit   is_mem = (op == 6'h23) || (op == 6'h2B);
      for (int i = 0; i <= fw; i++) begin
         e = blank(3'd1);
         e.mem_req   = 1'b1;
         e.alu_src_b = 2'd1;
         e.ir_write  = (i == fw);
         e.pc_write  = (i == fw);
         drive_cycle(e, logic'(i == fw), rnd_bit(), cur_op);
      end
      cur_op = op;

      e = blank(3'd2);
      e.alu_src_b = 2'd3;
      e.ext_sign  = 1'b1;
      if (op == 6'h02) begin
         e.pc_write = 1'b1;
         e.pc_src   = 2'd2;
      end
      e.illegal = !legal;
      drive_cycle(e, rnd_bit(), rnd_bit(), op);
      if (op == 6'h02 || !legal) return;

      e = blank(3'd3);
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'd2;
      case (op)
         6'h00: begin e.alu_src_b = 2'd0; e.alu_op = 3'd2; end
         6'h08: e.ext_sign = 1'b1;
         6'h0A: begin e.alu_op = 3'd3; e.ext_sign = 1'b1; end
         6'h0C: e.alu_op = 3'd5;
         6'h0D: e.alu_op = 3'd4;
         6'h23, 6'h2B: e.ext_sign = 1'b1;
         default: begin
            e.alu_src_b = 2'd0;
            e.alu_op    = 3'd1;
            e.pc_src    = 2'd1;
            e.pc_write  = (op == 6'h04) ? zero : !zero;
         end
      endcase
      drive_cycle(e, rnd_bit(), zero, op);
      if (branch) return;

      if (is_mem) begin
         for (int i = 0; i <= mw; i++) begin
            e = blank(3'd4);
            e.mem_req   = 1'b1;
            e.mem_write = (op == 6'h2B);
            drive_cycle(e, logic'(i == mw), rnd_bit(), op);
         end
         if (op == 6'h2B) return;
      end

      e = blank(3'd5);
      e.reg_write  = 1'b1;
      e.reg_dst    = (op == 6'h00);
      e.mem_to_reg = (op == 6'h23);
      drive_cycle(e, rnd_bit(), rnd_bit(), op);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         cycle_no++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", act, e);
         end
      end
   end

   initial begin : stimulus
      exp_t e;
      logic [5:0] op;
      rst_i       = 1'b0;
      mem_ready_i = 1'b0;
      zero_i      = 1'b0;
      instr_op_i  = 6'h00;

      repeat (3) drive_cycle(blank(3'd0), 1'b1, 1'b1, 6'h00);
      drive_cycle(blank(3'd0), 1'b0, 1'b0, 6'h00);
      rst_i = 1'b1;

      // Two FETCH wait cycles, then reset asserted mid-cycle while the request is pending.
      e = blank(3'd1);
      e.mem_req   = 1'b1;
      e.alu_src_b = 2'd1;
      repeat (2) drive_cycle(e, 1'b0, 1'b0, 6'h00);
      @(posedge clk_i);
      #1;
      check("fetch_before_reset", act, e);
      #1 rst_i = 1'b0;
      #1 check("async_reset", act, blank(3'd0));
      drive_cycle(blank(3'd0), 1'b1, 1'b1, 6'h00);
      drive_cycle(blank(3'd0), 1'b0, 1'b0, 6'h00);
      rst_i = 1'b1;

      // Directed instructions.
      run_instr(6'h00, 1'b0, 0, 0);
      run_instr(6'h08, 1'b0, 0, 0);
      run_instr(6'h0D, 1'b1, 0, 0);
      run_instr(6'h0C, 1'b0, 0, 0);
      run_instr(6'h0A, 1'b1, 0, 0);
      run_instr(6'h23, 1'b0, 2, 2);
      run_instr(6'h04, 1'b1, 0, 0);
      run_instr(6'h04, 1'b0, 0, 0);
      run_instr(6'h05, 1'b1, 0, 0);
      run_instr(6'h05, 1'b0, 0, 0);
      run_instr(6'h2B, 1'b0, 1, 3);
      run_instr(6'h02, 1'b0, 0, 0);
      run_instr(6'h3F, 1'b0, 0, 0);

      // Randomized instruction stream with random wait states.
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            op = LEGAL_OPS[$urandom_range(0, 9)];
         end else begin
            do op = 6'($urandom_range(0, 63)); while (is_legal(op));
         end
         run_instr(op, rnd_bit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      @(negedge clk_i);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
